// File: rtl/gmii_rx_frame_parser_if.sv
// GMII receive parser bus bundle.
// Carries the raw GMII receive byte stream into the parser and the parsed
// payload stream plus frame counters back out.
//   master : drives gmii_rxd/gmii_rx_dv/gmii_rx_er, observes the parser outputs
//   slave  : the parser itself
interface gmii_rx_frame_parser_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       gmii_rxd;
  logic             gmii_rx_dv;
  logic             gmii_rx_er;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_sof;
  logic             rx_eof;
  logic             rx_crc_ok;
  logic             rx_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err,
    input  frame_cnt, err_cnt
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err,
    output frame_cnt, err_cnt
  );
endinterface

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser.
// Finds preamble/SFD, strips preamble, SFD and FCS, and streams payload
// bytes with sof/eof markers. Checks CRC-32 over everything after the SFD,
// flags errored/truncated frames and keeps saturating good/bad counters.
// Ports:
//   gmii_rx_clk : receive clock, all logic on its rising edge
//   reset       : synchronous, active-high
//   bus         : gmii_rxd/dv/er in; rx_data/valid/sof/eof/crc_ok/err and
//                 frame_cnt/err_cnt out (all registered)
module gmii_rx_frame_parser #(
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input logic                  gmii_rx_clk,
  input logic                  reset,
  gmii_rx_frame_parser_if.slave bus
);
  localparam int              NW          = $clog2(MAX_LEN + 6);
  localparam logic [NW-1:0]   N_SOF       = NW'(5);
  localparam logic [NW-1:0]   N_OVER      = NW'(MAX_LEN + 4);
  localparam logic [31:0]     CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]       state;
  logic [4:0][7:0]  sr;         // sr[0] newest, sr[4] = byte n-5
  logic [NW-1:0]    n;          // bytes captured since SFD
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic             err_flag;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err;
  logic [CNT_W-1:0] frame_cnt, err_cnt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb crc_next = crc_byte(crc, bus.gmii_rxd);

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sr        <= '0;
      n         <= '0;
      crc       <= '1;
      err_flag  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_crc_ok <= 1'b0;
      rx_err    <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_crc_ok <= 1'b0;
      rx_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.gmii_rx_dv) begin
            if (bus.gmii_rxd == 8'h55) state <= S_PRE;
            else begin
              state   <= S_DROP;
              err_cnt <= sat_inc(err_cnt);
            end
          end
        end
        S_PRE: begin
          if (!bus.gmii_rx_dv) begin
            state   <= S_IDLE;
            err_cnt <= sat_inc(err_cnt);
          end else if (bus.gmii_rxd == 8'hD5) begin
            state    <= S_DATA;
            n        <= '0;
            crc      <= '1;
            err_flag <= 1'b0;
          end else if (bus.gmii_rxd != 8'h55) begin
            state   <= S_DROP;
            err_cnt <= sat_inc(err_cnt);
          end
        end
        S_DATA: begin
          if (bus.gmii_rx_dv) begin
            if (n == N_OVER) begin
              // Byte would push the frame past MAX_LEN+FCS: close it out
              // as truncated and discard the remainder.
              rx_valid <= 1'b1;
              rx_data  <= sr[4];
              rx_sof   <= (n == N_SOF);
              rx_eof   <= 1'b1;
              rx_err   <= 1'b1;
              state    <= S_DROP;
              err_cnt  <= sat_inc(err_cnt);
            end else begin
              sr       <= {sr[3:0], bus.gmii_rxd};
              crc      <= crc_next;
              n        <= n + 1'b1;
              err_flag <= err_flag | bus.gmii_rx_er;
              // Holding back 4 bytes means the FCS never reaches the output.
              if (n >= N_SOF) begin
                rx_valid <= 1'b1;
                rx_data  <= sr[4];
                rx_sof   <= (n == N_SOF);
              end
            end
          end else begin
            state <= S_IDLE;
            if (n >= N_SOF) begin
              rx_valid  <= 1'b1;
              rx_data   <= sr[4];
              rx_sof    <= (n == N_SOF);
              rx_eof    <= 1'b1;
              rx_crc_ok <= (crc == CRC_RESIDUE);
              rx_err    <= err_flag;
              if ((crc == CRC_RESIDUE) && !err_flag) frame_cnt <= sat_inc(frame_cnt);
              else                                   err_cnt   <= sat_inc(err_cnt);
            end else begin
              err_cnt <= sat_inc(err_cnt);   // runt
            end
          end
        end
        default: begin
          if (!bus.gmii_rx_dv) state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.rx_sof    = rx_sof;
  assign bus.rx_eof    = rx_eof;
  assign bus.rx_crc_ok = rx_crc_ok;
  assign bus.rx_err    = rx_err;
  assign bus.frame_cnt = frame_cnt;
  assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Bench for gmii_rx_frame_parser: instance A (MAX_LEN=16) carries the frame
// tests with a payload scoreboard; instance B (CNT_W=2) checks saturation.
module tb_gmii_rx_frame_parser;
  localparam int MAX_A = 16;
  localparam int MAX_B = 1518;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxd = 8'h00;
  logic       dv = 1'b0, er = 1'b0, en_b = 1'b0;

  always #5 clk = ~clk;

  gmii_rx_frame_parser_if #(.CNT_W(16)) bus_a ();
  gmii_rx_frame_parser_if #(.CNT_W(2))  bus_b ();

  assign bus_a.gmii_rxd   = rxd;
  assign bus_a.gmii_rx_dv = dv & ~en_b;
  assign bus_a.gmii_rx_er = er;
  assign bus_b.gmii_rxd   = rxd;
  assign bus_b.gmii_rx_dv = dv & en_b;
  assign bus_b.gmii_rx_er = er;

  gmii_rx_frame_parser #(.MAX_LEN(MAX_A), .CNT_W(16)) dut_a (
    .gmii_rx_clk(clk), .reset(rst), .bus(bus_a.slave));
  gmii_rx_frame_parser #(.MAX_LEN(MAX_B), .CNT_W(2)) dut_b (
    .gmii_rx_clk(clk), .reset(rst), .bus(bus_b.slave));

  typedef struct packed {
    logic [7:0] d;
    logic       sof, eof, ok, err;
  } beat_t;

  beat_t q[$];
  beat_t mon_x;
  int checks = 0, fails = 0;
  int exp_fa = 0, exp_ea = 0, exp_fb = 0, exp_eb = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Standard CRC-32 (as appended LSB-first in the FCS) of the first len bytes.
  function automatic logic [31:0] crc_of(input logic [7:0] b[$], input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk);
    rxd = b; dv = v; er = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic push_beat(input logic [7:0] d, input logic s, input logic e,
                           input logic ok, input logic err);
    beat_t x;
    x.d = d; x.sof = s; x.eof = e; x.ok = ok; x.err = err;
    q.push_back(x);
  endtask

  // Expected outcome of one post-SFD byte sequence (payload + FCS).
  task automatic model(input logic [7:0] b[$], input int er_idx);
    int   n  = b.size();
    int   mx = en_b ? MAX_B : MAX_A;
    logic ok, e;
    bit   good = 0;
    if (n > mx + 4) begin
      if (!en_b) for (int i = 0; i < mx; i++) push_beat(b[i], i == 0, i == mx - 1, 1'b0, 1'b1);
    end else if (n >= 5) begin
      ok = (crc_of(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]});
      e  = (er_idx >= 0) && (er_idx < n);
      if (!en_b) for (int i = 0; i <= n - 5; i++) push_beat(b[i], i == 0, i == n - 5, ok, e);
      good = ok && !e;
    end
    if (en_b) begin
      if (good) exp_fb = (exp_fb < 3) ? exp_fb + 1 : 3;
      else      exp_eb = (exp_eb < 3) ? exp_eb + 1 : 3;
    end else begin
      if (good) exp_fa++; else exp_ea++;
    end
  endtask

  task automatic send(input logic [7:0] b[$], input int er_idx);
    model(b, er_idx);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (b[i]) drive(b[i], 1'b1, (i == er_idx) ? 1'b1 : 1'b0);
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic mk_good(input logic [7:0] pl[$], output logic [7:0] f[$]);
    logic [31:0] c = crc_of(pl, pl.size());
    f = pl;
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
  endtask

  task automatic check_a(input string tag);
    idle(4);
    chk({tag, "_frame_cnt"}, bus_a.frame_cnt, exp_fa);
    chk({tag, "_err_cnt"},   bus_a.err_cnt,   exp_ea);
    chk({tag, "_drain"},     q.size(),        0);
  endtask

  always @(negedge clk) begin
    if (bus_a.rx_valid) begin
      if (q.size() == 0) chk("extra_beat", bus_a.rx_valid, 1'b0);
      else begin
        mon_x = q.pop_front();
        chk("data", bus_a.rx_data, mon_x.d);
        chk("sof",  bus_a.rx_sof,  mon_x.sof);
        chk("eof",  bus_a.rx_eof,  mon_x.eof);
        if (mon_x.eof) begin
          chk("crc_ok", bus_a.rx_crc_ok, mon_x.ok);
          chk("err",    bus_a.rx_err,    mon_x.err);
        end
      end
    end
  end

  initial begin
    logic [7:0] f[$], r[$], big[$], pl[$], g[$];
    repeat (2) @(negedge clk);
    chk("rst_valid",  bus_a.rx_valid,  1'b0);
    chk("rst_data",   bus_a.rx_data,   8'h00);
    chk("rst_sof",    bus_a.rx_sof,    1'b0);
    chk("rst_eof",    bus_a.rx_eof,    1'b0);
    chk("rst_crc_ok", bus_a.rx_crc_ok, 1'b0);
    chk("rst_err",    bus_a.rx_err,    1'b0);
    chk("rst_fcnt",   bus_a.frame_cnt, 0);
    chk("rst_ecnt",   bus_a.err_cnt,   0);
    rst = 1'b0;
    idle(2);

    // "123456789" with its known FCS
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send(f, -1);
    check_a("good");

    f[12] = 8'hCA;
    send(f, -1);
    check_a("badfcs");
    f[12] = 8'hCB;

    send(f, 4);              // rx_er on 0x35
    check_a("rxer");

    r = '{8'h31, 8'h32, 8'h33, 8'h34};
    send(r, -1);
    check_a("runt");

    // Preamble corruption, then a good frame one idle cycle later
    exp_ea++;
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hAA, 1'b1, 1'b0);
    drive(8'h11, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    send(f, -1);
    check_a("pre_err");

    for (int i = 0; i < 30; i++) big.push_back(8'(i + 1));
    send(big, -1);
    check_a("oversize");

    // Back-to-back: shortest frame (sof==eof), mid, and exactly MAX_LEN
    foreach (g[i]) g.delete(i);
    for (int len = 1; len <= 16; len = (len == 1) ? 8 : len * 2) begin
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      mk_good(pl, g);
      send(g, -1);
    end
    check_a("b2b");

    // Saturation on the 2-bit counter instance
    en_b = 1'b1;
    repeat (4) send(f, -1);
    f[12] = 8'hCA;
    send(f, -1);
    f[12] = 8'hCB;
    idle(4);
    chk("sat_frame_cnt", bus_b.frame_cnt, exp_fb);
    chk("sat_err_cnt",   bus_b.err_cnt,   exp_eb);
    chk("a_idle_fcnt",   bus_a.frame_cnt, exp_fa);
    en_b = 1'b0;
    idle(1);

    // Reset mid-payload: three bytes already emitted, then abort
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push_beat(f[i], i == 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(f[i], 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus_a.rx_valid,  1'b0);
    chk("mid_rst_data",  bus_a.rx_data,   8'h00);
    chk("mid_rst_eof",   bus_a.rx_eof,    1'b0);
    chk("mid_rst_fcnt",  bus_a.frame_cnt, 0);
    chk("mid_rst_ecnt",  bus_a.err_cnt,   0);
    chk("mid_rst_bcnt",  bus_b.frame_cnt, 0);
    rst = 1'b0;
    exp_fa = 0; exp_ea = 0;
    check_a("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
